// File: rtl/divide_pkg.sv
// divide_pkg: shared constants, FSM state type and magnitude helper for the divider.
package divide_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = 5'd31;
    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    // |INT_MIN| wraps back to INT_MIN, which is the correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? -x : x;
    endfunction
endpackage

// File: rtl/division_counter.sv
// division_counter: 5-bit iteration counter with sync clear, enable and terminal-count flag.
module division_counter
    import divide_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign last_o = cnt_q == DIV_LAST;
endmodule

// File: rtl/divide.sv
// divide: 32-cycle restoring signed divider; quotient truncates toward zero,
// divide-by-zero and INT_MIN/-1 raise data_exception.
module divide
    import divide_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    div_state_t state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d, res_q, res_d;
    logic sign_q, sign_d, dz_q, dz_d, ovf_q, ovf_d, exc_q, exc_d;
    logic last, fin;
    logic [WIDTH:0] shifted, t;
    logic [WIDTH-1:0] qn;

    division_counter u_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .clr_i  (ctrl_DIV),
        .en_i   (state_q == RUN),
        .last_o (last)
    );

    assign shifted = {r_q, q_q[WIDTH-1]};
    assign t = shifted - {1'b0, d_q};
    assign qn = {q_q[WIDTH-2:0], ~t[WIDTH]};
    // A new start pulse always wins, including on the would-be final iteration.
    assign fin = state_q == RUN && last && !ctrl_DIV;

    always_comb state_d = ctrl_DIV ? RUN : (state_q == RUN) ? (last ? DONE : RUN) : IDLE;

    always_comb begin
        q_d = q_q;
        r_d = r_q;
        d_d = d_q;
        sign_d = sign_q;
        dz_d = dz_q;
        ovf_d = ovf_q;
        res_d = res_q;
        exc_d = exc_q;
        if (ctrl_DIV) begin
            q_d = div_abs(data_operandA);
            d_d = div_abs(data_operandB);
            r_d = '0;
            sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d = data_operandB == '0;
            ovf_d = data_operandA == INT_MIN && data_operandB == '1;
        end else if (state_q == RUN) begin
            q_d = qn;
            r_d = t[WIDTH] ? shifted[WIDTH-1:0] : t[WIDTH-1:0];
        end
        if (fin) begin
            res_d = dz_q ? '0 : ovf_q ? INT_MIN : sign_q ? -qn : qn;
            exc_d = dz_q | ovf_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            q_q <= '0;
            r_q <= '0;
            d_q <= '0;
            sign_q <= 1'b0;
            dz_q <= 1'b0;
            ovf_q <= 1'b0;
            res_q <= '0;
            exc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q <= q_d;
            r_q <= r_d;
            d_q <= d_d;
            sign_q <= sign_d;
            dz_q <= dz_d;
            ovf_q <= ovf_d;
            res_q <= res_d;
            exc_q <= exc_d;
        end

    assign data_result = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = state_q == DONE;
endmodule

// File: tb/tb_divide.sv
// tb_divide: scoreboard bench; a driver queues expected quotients from a signed-arithmetic model,
// a negedge monitor checks each RDY pulse for value, exception flag and cycle of arrival.
module tb_divide;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic data_exception, data_resultRDY;

    typedef struct {
        logic [31:0] res;
        logic exc;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    divide dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint q;
        if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = q[31:0];
            e = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // The pulse is sampled one edge after it is driven, and RDY shows 32 edges later.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input bit abort_prev);
        exp_t e;
        @(posedge clock);
        #1;
        if (abort_prev && exp_q.size() > 0) void'(exp_q.pop_back());
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        model(a, b, e.res, e.exc);
        e.cyc = cyc + 33;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        start(a, b, 1'b0);
        repeat (34) @(posedge clock);
    endtask

    always @(negedge clock)
        if (data_resultRDY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rdy: RDY at cycle %0d with nothing pending", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("latency_cycle", cyc, e.cyc);
            end
        end

    initial begin
        logic [31:0] a, b;
        repeat (2) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset_n = 1'b1;

        run(32'd100, 32'd7);
        run(-32'sd100, 32'd7);
        run(32'd100, -32'sd7);
        run(-32'sd100, -32'sd7);
        run(32'd7, 32'd100);
        run(-32'sd7, 32'd2);
        run(32'd12345, 32'd0);
        run(32'h8000_0000, 32'hFFFF_FFFF);
        run(32'h8000_0000, 32'd1);
        run(32'h7FFF_FFFF, 32'h8000_0000);
        run(32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom >> $urandom_range(0, 31);
            run(a, b);
        end

        start(32'd100, 32'd7, 1'b0);
        repeat (8) @(posedge clock);
        start(32'd81, 32'd9, 1'b1);
        repeat (34) @(posedge clock);

        start(32'd500, -32'sd3, 1'b0);
        repeat (31) @(posedge clock);
        start(32'd77, 32'd11, 1'b0);
        repeat (34) @(posedge clock);

        start(32'd1000, 32'd10, 1'b0);
        repeat (13) @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_result", data_result, 32'd0);
        check("async_reset_exc", {31'd0, data_exception}, 32'd0);
        check("async_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        run(32'd1000, 32'd10);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending: %0d results never arrived, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
